accel_dmem_responder: RTL

Accelerator-side responder for the CPU accelerator bus (`accel_en` / `accel_done` / `bus_wr` / `bus_data` / register address). It exposes an 8-entry register file to the CPU. On command it streams 256-bit lines from DMEM port B (the `rden_b` / `q_b` side, opposite the CCD writer) and reduces them into a 32-bit signed accumulator. It replaces the constant-`16'h1234` bus mock in the top level.

---
 rtl/accel_dmem_responder_pkg.sv | 39 +++
 rtl/accel_dmem_responder_if.sv | 21 ++
 rtl/accel_dmem_responder_line_sum16.sv | 29 ++
 rtl/accel_dmem_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/accel_dmem_responder_pkg.sv
// Shared definitions for the accelerator DMEM responder: register map,
// FSM state encodings and datapath widths.
package accel_pkg;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_SRC     = 3'd2;
  localparam logic [2:0] REG_LEN     = 3'd3;
  localparam logic [2:0] REG_ACC_LO  = 3'd4;
  localparam logic [2:0] REG_ACC_HI  = 3'd5;
  localparam logic [2:0] REG_SCRATCH = 3'd6;
  localparam logic [2:0] REG_ID      = 3'd7;

  localparam int LINE_WORDS = 16;
  localparam int WORD_W     = 16;
  localparam int ACC_W      = 32;
  localparam int SUM_W      = 20;

  localparam logic [7:0] LEN_MAX = 8'd128;

  typedef enum logic [1:0] {
    B_IDLE    = 2'd0,
    B_ACT     = 2'd1,
    B_DONE    = 2'd2,
    B_WAITLOW = 2'd3
  } bus_state_t;

  typedef enum logic [1:0] {
    J_IDLE  = 2'd0,
    J_ISSUE = 2'd1,
    J_DRAIN = 2'd2
  } job_state_t;

  // A line count never exceeds the size of DMEM port B.
  function automatic logic [7:0] clamp_len(input logic [7:0] v);
    return (v > LEN_MAX) ? LEN_MAX : v;
  endfunction

endpackage

// File: rtl/accel_dmem_responder_if.sv
// CPU accelerator bus bundle; the CPU side is the master, the responder the slave.
interface accel_dmem_responder_if;
  logic        bus_en;
  logic        bus_start;
  logic        bus_wr;
  logic [2:0]  bus_regaddr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_rdata_oe;
  logic        bus_done;

  modport master (
    output bus_en, bus_start, bus_wr, bus_regaddr, bus_wdata,
    input  bus_rdata, bus_rdata_oe, bus_done
  );

  modport slave (
    input  bus_en, bus_start, bus_wr, bus_regaddr, bus_wdata,
    output bus_rdata, bus_rdata_oe, bus_done
  );
endinterface

// File: rtl/accel_dmem_responder_line_sum16.sv
// Combinational signed adder tree: sixteen 16-bit words of a DMEM line to a
// 20-bit sum. Each level grows by one bit so no level can overflow.
module line_sum16
  import accel_pkg::*;
(
  input  logic [LINE_WORDS*WORD_W-1:0] i_line,
  output logic [SUM_W-1:0]             o_sum
);

  logic [16:0] w_l1 [8];
  logic [17:0] w_l2 [4];
  logic [18:0] w_l3 [2];

  // Pairwise sign-extended additions, four levels deep.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_l1[i] = {i_line[32*i+15], i_line[32*i +: 16]}
              + {i_line[32*i+31], i_line[32*i+16 +: 16]};
    end
    for (int i = 0; i < 4; i++) begin
      w_l2[i] = {w_l1[2*i][16], w_l1[2*i]} + {w_l1[2*i+1][16], w_l1[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      w_l3[i] = {w_l2[2*i][17], w_l2[2*i]} + {w_l2[2*i+1][17], w_l2[2*i+1]};
    end
    o_sum = {w_l3[0][18], w_l3[0]} + {w_l3[1][18], w_l3[1]};
  end

endmodule

// File: rtl/accel_dmem_responder.sv
// Accelerator-side bus responder: 8-entry register file plus a job engine that
// streams DMEM port-B lines into a wrapping 32-bit signed accumulator.
module accel_dmem_responder
  import accel_pkg::*;
#(
  parameter int          RD_LAT = 2,
  parameter logic [15:0] ID_VAL = 16'hACC1
) (
  input  logic                          clk,
  input  logic                          rst,
  accel_dmem_responder_if.slave         bus,
  output logic                          dmem_rden,
  output logic [6:0]                    dmem_addr,
  input  logic [LINE_WORDS*WORD_W-1:0]  dmem_q
);

  bus_state_t        r_bstate, w_bnext;
  job_state_t        r_jstate, w_jnext;

  logic [2:0]        r_ra;
  logic              r_wr;
  logic [15:0]       r_wd;
  logic              r_launched;

  logic [6:0]        r_src;
  logic [7:0]        r_len;
  logic [15:0]       r_scratch;
  logic              r_busy;
  logic              r_sticky;
  logic [ACC_W-1:0]  r_acc;

  logic              r_rden;
  logic [6:0]        r_daddr;
  logic [7:0]        r_cnt;
  logic [RD_LAT-1:0] r_vld;
  logic [SUM_W-1:0]  r_s1;
  logic              r_s1_vld;

  logic              r_done;
  logic              r_oe;
  logic [15:0]       r_rdata;

  logic              w_cap;
  logic              w_launch;
  logic              w_access;
  logic              w_issue;
  logic              w_job_done;
  logic [15:0]       w_rmux;
  logic [SUM_W-1:0]  w_sum;

  assign bus.bus_done     = r_done;
  assign bus.bus_rdata_oe = r_oe;
  assign bus.bus_rdata    = r_rdata;
  assign dmem_rden        = r_rden;
  assign dmem_addr        = r_daddr;

  // A START is decoded straight from the bus so the first read issues next cycle.
  assign w_cap    = (r_bstate == B_IDLE) && bus.bus_en && bus.bus_start;
  assign w_launch = w_cap && !bus.bus_wr && (bus.bus_regaddr == REG_CTRL)
                    && bus.bus_wdata[0] && !r_busy;
  assign w_access = (r_bstate == B_ACT) && !(r_launched && r_busy);

  line_sum16 u_sum (
    .i_line (dmem_q),
    .o_sum  (w_sum)
  );

  // Bus FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_bstate <= B_IDLE;
    else     r_bstate <= w_bnext;
  end

  // Bus FSM next state.
  always_comb begin
    w_bnext = r_bstate;
    case (r_bstate)
      B_IDLE:    if (w_cap) w_bnext = B_ACT; else w_bnext = B_IDLE;
      B_ACT:     if (w_access) w_bnext = B_DONE; else w_bnext = B_ACT;
      B_DONE:    w_bnext = B_WAITLOW;
      B_WAITLOW: if (!bus.bus_start || !bus.bus_en) w_bnext = B_IDLE;
                 else w_bnext = B_WAITLOW;
      default:   w_bnext = B_IDLE;
    endcase
  end

  // Register read mux.
  always_comb begin
    w_rmux = 16'd0;
    case (r_ra)
      REG_CTRL:    w_rmux = 16'd0;
      REG_STATUS:  w_rmux = {14'd0, r_sticky, r_busy};
      REG_SRC:     w_rmux = {9'd0, r_src};
      REG_LEN:     w_rmux = {8'd0, r_len};
      REG_ACC_LO:  w_rmux = r_acc[15:0];
      REG_ACC_HI:  w_rmux = r_acc[31:16];
      REG_SCRATCH: w_rmux = r_scratch;
      REG_ID:      w_rmux = ID_VAL;
      default:     w_rmux = 16'd0;
    endcase
  end

  // Access capture, register writes and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ra       <= 3'd0;
      r_wr       <= 1'b0;
      r_wd       <= 16'd0;
      r_launched <= 1'b0;
      r_src      <= 7'd0;
      r_len      <= 8'd0;
      r_scratch  <= 16'd0;
      r_done     <= 1'b0;
      r_oe       <= 1'b0;
      r_rdata    <= 16'd0;
    end else begin
      if (w_cap) begin
        r_ra       <= bus.bus_regaddr;
        r_wr       <= bus.bus_wr;
        r_wd       <= bus.bus_wdata;
        r_launched <= w_launch;
      end
      if (w_access && !r_wr) begin
        case (r_ra)
          REG_SRC:     if (!r_busy) r_src <= r_wd[6:0];
          REG_LEN:     if (!r_busy) r_len <= clamp_len(r_wd[7:0]);
          REG_SCRATCH: r_scratch <= r_wd;
          default:     ;
        endcase
      end
      r_done  <= (w_bnext == B_DONE);
      r_oe    <= (w_bnext == B_DONE) && r_wr;
      r_rdata <= ((w_bnext == B_DONE) && r_wr) ? w_rmux : 16'd0;
    end
  end

  // Job FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_jstate <= J_IDLE;
    else     r_jstate <= w_jnext;
  end

  // Job FSM next state, read issue and completion decode.
  always_comb begin
    w_jnext    = r_jstate;
    w_issue    = 1'b0;
    w_job_done = 1'b0;
    case (r_jstate)
      J_IDLE: begin
        if (w_launch) begin
          w_issue = (r_len != 8'd0);
          w_jnext = (r_len != 8'd0) ? J_ISSUE : J_DRAIN;
        end else begin
          w_jnext = J_IDLE;
        end
      end
      J_ISSUE: begin
        if (r_cnt < r_len) w_issue = 1'b1;
        else               w_jnext = J_DRAIN;
      end
      J_DRAIN: begin
        // The S1->accumulator add still in flight lands on this same edge.
        if (!r_rden && (r_vld == '0)) begin
          w_job_done = 1'b1;
          w_jnext    = J_IDLE;
        end else begin
          w_jnext = J_DRAIN;
        end
      end
      default: w_jnext = J_IDLE;
    endcase
  end

  // Read issue, valid pipeline, line-sum stage and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rden   <= 1'b0;
      r_daddr  <= 7'd0;
      r_cnt    <= 8'd0;
      r_vld    <= '0;
      r_s1     <= '0;
      r_s1_vld <= 1'b0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_rden <= w_issue;
      if (w_launch) begin
        r_daddr <= r_src;
        r_cnt   <= (r_len != 8'd0) ? 8'd1 : 8'd0;
      end else if (w_issue) begin
        r_daddr <= r_daddr + 7'd1;
        r_cnt   <= r_cnt + 8'd1;
      end
      r_vld[0] <= r_rden;
      for (int k = 1; k < RD_LAT; k++) r_vld[k] <= r_vld[k-1];
      r_s1_vld <= r_vld[RD_LAT-1];
      if (r_vld[RD_LAT-1]) r_s1 <= w_sum;
      if (w_launch)      r_acc <= '0;
      else if (r_s1_vld) r_acc <= r_acc + {{(ACC_W-SUM_W){r_s1[SUM_W-1]}}, r_s1};
      if (w_launch) begin
        r_busy   <= 1'b1;
        r_sticky <= 1'b0;
      end else if (w_job_done) begin
        r_busy   <= 1'b0;
        r_sticky <= 1'b1;
      end
    end
  end

endmodule
